// File: rtl/if_fetch_unit_pkg.sv
// Purpose : shared definitions for the instruction-fetch front end.
//           Holds the fetch FSM encoding, the NOP instruction word and the
//           default sequential PC increment.
// Ports   : none (package).
package if_fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    // Fetch FSM encoding
    localparam logic [1:0] ST_REQ   = 2'd0;  // request outstanding
    localparam logic [1:0] ST_HOLD  = 2'd1;  // data captured, pipe stalled
    localparam logic [1:0] ST_FLUSH = 2'd2;  // outstanding request is stale

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP = 32'd4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Purpose : instruction-memory request/response bus between the fetch unit
//           (master) and the instruction SRAM/cache (slave).
// Signals : imem_req   - request, held high until imem_ready
//           imem_addr  - request address, stable while imem_req=1
//           imem_rdata - instruction word, valid when imem_ready=1
//           imem_ready - one-cycle completion strobe
interface if_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage. Owns the PC, issues requests to a
//           multi-cycle instruction memory and presents {PC+step,
//           Instruction, valid} to the IF/ID register. Honours pipeline
//           stall and branch redirect; raises fetch_stall while waiting.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           stall               - hold fetch output, do not advance
//           branch_taken/_addr  - one-cycle redirect and its target
//           mem (master)        - instruction memory bus
//           PC, Instruction     - registered IF/ID payload
//           valid               - payload holds a real instruction
//           fetch_stall         - memory busy, no data this cycle
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    if_fetch_unit_if.master    mem,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               valid,
    output logic               fetch_stall
);

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] flush_addr_r;  // address of the request being flushed
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] addr_s;
    logic              req_s;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_inc_s = pc_r + ADDR_W'(PC_STEP);

    // Request decode; reset suppresses the request in the cycle it is applied
    // so the memory sees a cancel.
    always_comb begin
        req_s = 1'b0;
        if (rst) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                ST_REQ:   req_s = 1'b1;
                ST_FLUSH: req_s = 1'b1;
                ST_HOLD:  req_s = 1'b0;
                default:  req_s = 1'b0;
            endcase
        end
    end

    // A flushed request cannot be aborted, so its address is held even
    // though pc_r already points at the redirect target.
    always_comb begin
        addr_s = pc_r;
        if (state_r == ST_FLUSH) begin
            addr_s = flush_addr_r;
        end else begin
            addr_s = pc_r;
        end
    end

    assign mem.imem_req  = req_s;
    assign mem.imem_addr = addr_s;
    assign fetch_stall   = req_s & ~mem.imem_ready;

    // PC, FSM and IF/ID output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            flush_addr_r <= RESET_PC;
            PC           <= {ADDR_W{1'b0}};
            Instruction  <= INSTR_W'(NOP_INSTR);
            valid        <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over stall and all state logic; any data
            // arriving this cycle belongs to the wrong path.
            pc_r        <= branch_addr;
            PC          <= {ADDR_W{1'b0}};
            Instruction <= INSTR_W'(NOP_INSTR);
            valid       <= 1'b0;
            if (req_s && !mem.imem_ready) begin
                state_r <= ST_FLUSH;
                // A second redirect while flushing keeps the original
                // in-flight address.
                if (state_r != ST_FLUSH) begin
                    flush_addr_r <= pc_r;
                end else begin
                    flush_addr_r <= flush_addr_r;
                end
            end else begin
                state_r <= ST_REQ;
            end
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (mem.imem_ready) begin
                        Instruction <= mem.imem_rdata;
                        PC          <= pc_inc_s;
                        valid       <= 1'b1;
                        pc_r        <= pc_inc_s;
                        state_r     <= stall ? ST_HOLD : ST_REQ;
                    end else if (!stall) begin
                        // bubble while waiting; a stalled pipe keeps its view
                        valid       <= 1'b0;
                        Instruction <= INSTR_W'(NOP_INSTR);
                    end else begin
                        valid <= valid;
                    end
                end
                ST_HOLD: begin
                    state_r <= stall ? ST_HOLD : ST_REQ;
                end
                ST_FLUSH: begin
                    if (mem.imem_ready) begin
                        valid       <= 1'b0;
                        Instruction <= INSTR_W'(NOP_INSTR);
                        state_r     <= ST_REQ;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r     <= ST_REQ;
                    valid       <= 1'b0;
                    Instruction <= INSTR_W'(NOP_INSTR);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: hand-written reset, two streaming runs with a
// bench-side memory of fixed latency, then a table of per-cycle vectors for
// stall/hold, flush, redirect-with-ready, wrap and reset mid-request.
// Registered-output expectations go through a scoreboard queue.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;
    logic        fetch_stall;

    int tests;
    int fails;

    if_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) mem_bus ();

    if_fetch_unit #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .mem         (mem_bus),
        .PC          (PC),
        .Instruction (Instruction),
        .valid       (valid),
        .fetch_stall (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fs;
        logic        e_v;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    typedef struct {
        string       name;
        logic        v;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    // memory content: a recognisable function of the address
    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic s, input logic b,
                                input logic [31:0] ba, input logic rdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_fs, input logic e_v,
                                input logic chk_pc, input logic [31:0] e_pc,
                                input logic [31:0] e_ins);
        vec_t v;
        v.name = n; v.rst = r; v.stall = s; v.br = b; v.baddr = ba; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fs = e_fs; v.e_v = e_v;
        v.chk_pc = chk_pc; v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic push_exp(input string n, input logic v, input logic cp,
                            input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.name = n; e.v = v; e.chk_pc = cp; e.pc = pc; e.ins = ins;
        exp_q.push_back(e);
    endtask

    // compare registered outputs produced by the last posedge
    task automatic check_q();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, "_valid"}, {31'd0, valid}, {31'd0, e.v});
            chk({e.name, "_instr"}, Instruction, e.ins);
            if (e.chk_pc) chk({e.name, "_pc"}, PC, e.pc);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        check_q();
        rst          = v.rst;
        stall        = v.stall;
        branch_taken = v.br;
        branch_addr  = v.baddr;
        mem_bus.imem_ready = v.rdy;
        mem_bus.imem_rdata = v.rdy ? rd(v.e_addr) : 32'hDEAD_BEEF;
        #1;
        chk({v.name, "_req"}, {31'd0, mem_bus.imem_req}, {31'd0, v.e_req});
        if (v.e_req) chk({v.name, "_addr"}, mem_bus.imem_addr, v.e_addr);
        chk({v.name, "_fstall"}, {31'd0, fetch_stall}, {31'd0, v.e_fs});
        push_exp(v.name, v.e_v, v.chk_pc, v.e_pc, v.e_ins);
    endtask

    // memory answering each request in its lat-th request cycle
    task automatic run_stream(input int n, input int lat, input logic [31:0] start);
        logic [31:0] a;
        int cnt;
        int got;
        int guard;
        a = start; cnt = 0; got = 0; guard = 0;
        while (got < n && guard < 200) begin
            @(negedge clk);
            check_q();
            guard++;
            cnt++;
            rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
            mem_bus.imem_ready = (cnt == lat);
            mem_bus.imem_rdata = (cnt == lat) ? rd(a) : 32'hDEAD_BEEF;
            #1;
            chk($sformatf("stream_l%0d_req", lat), {31'd0, mem_bus.imem_req}, 32'd1);
            chk($sformatf("stream_l%0d_addr", lat), mem_bus.imem_addr, a);
            chk($sformatf("stream_l%0d_fstall", lat), {31'd0, fetch_stall},
                {31'd0, (cnt != lat)});
            if (cnt == lat) begin
                push_exp($sformatf("stream_l%0d_data%0h", lat, a), 1'b1, 1'b1, a + 32'd4, rd(a));
                a = a + 32'd4;
                got++;
                cnt = 0;
            end else begin
                push_exp($sformatf("stream_l%0d_bubble", lat), 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk($sformatf("stream_l%0d_done", lat), got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        mem_bus.imem_ready = 1'b0;
        mem_bus.imem_rdata = 32'h0;

        // name, rst, stall, br, baddr, rdy, e_req, e_addr, e_fs, e_v, chk_pc, e_pc, e_ins
        tbl.push_back(mk("t_rst",          1,0,0,32'h0,        0, 0,32'h0,        0, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_idle0",        0,0,0,32'h0,        0, 1,32'h0,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch0",       0,0,0,32'h0,        1, 1,32'h0,        0, 1,1,32'h4, rd(32'h0)));
        tbl.push_back(mk("t_wait4",        0,0,0,32'h0,        0, 1,32'h4,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch4",       0,0,0,32'h0,        1, 1,32'h4,        0, 1,1,32'h8, rd(32'h4)));
        tbl.push_back(mk("t_wait8",        0,0,0,32'h0,        0, 1,32'h8,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_stall_fetch8", 0,1,0,32'h0,        1, 1,32'h8,        0, 1,1,32'hC, rd(32'h8)));
        tbl.push_back(mk("t_hold_a",       0,1,0,32'h0,        0, 0,32'h0,        0, 1,1,32'hC, rd(32'h8)));
        tbl.push_back(mk("t_hold_b",       0,1,0,32'h0,        0, 0,32'h0,        0, 1,1,32'hC, rd(32'h8)));
        tbl.push_back(mk("t_hold_release", 0,0,0,32'h0,        0, 0,32'h0,        0, 1,1,32'hC, rd(32'h8)));
        tbl.push_back(mk("t_req12",        0,0,0,32'h0,        0, 1,32'hC,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch12",      0,0,0,32'h0,        1, 1,32'hC,        0, 1,1,32'h10,rd(32'hC)));
        tbl.push_back(mk("t_wait16",       0,0,0,32'h0,        0, 1,32'h10,       1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_br40_out",     0,0,1,32'h40,       0, 1,32'h10,       1, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_flush_wait",   0,0,0,32'h0,        0, 1,32'h10,       1, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_flush_drop",   0,0,0,32'h0,        1, 1,32'h10,       0, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_wait40",       0,0,0,32'h0,        0, 1,32'h40,       1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_br80_rdy_stl", 0,1,1,32'h80,       1, 1,32'h40,       0, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_wait80",       0,0,0,32'h0,        0, 1,32'h80,       1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch80",      0,0,0,32'h0,        1, 1,32'h80,       0, 1,1,32'h84,rd(32'h80)));
        tbl.push_back(mk("t_wait84",       0,0,0,32'h0,        0, 1,32'h84,       1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_br100_out",    0,0,1,32'h100,      0, 1,32'h84,       1, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_br_max_flush", 0,0,1,32'hFFFF_FFFC,0, 1,32'h84,       1, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_flush2_drop",  0,0,0,32'h0,        1, 1,32'h84,       0, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_wait_max",     0,0,0,32'h0,        0, 1,32'hFFFF_FFFC,1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch_max",    0,0,0,32'h0,        1, 1,32'hFFFF_FFFC,0, 1,1,32'h0, rd(32'hFFFF_FFFC)));
        tbl.push_back(mk("t_wait_wrap0",   0,0,0,32'h0,        0, 1,32'h0,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch_wrap0",  0,0,0,32'h0,        1, 1,32'h0,        0, 1,1,32'h4, rd(32'h0)));
        tbl.push_back(mk("t_wait4b",       0,0,0,32'h0,        0, 1,32'h4,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_rst_mid",      1,0,0,32'h0,        0, 0,32'h0,        0, 0,1,32'h0, 32'h0));
        tbl.push_back(mk("t_req_after_rst",0,0,0,32'h0,        0, 1,32'h0,        1, 0,0,32'h0, 32'h0));
        tbl.push_back(mk("t_fetch_aft_rst",0,0,0,32'h0,        1, 1,32'h0,        0, 1,1,32'h4, rd(32'h0)));

        // reset held for two cycles: no request, cleared outputs
        apply_vec(mk("rst_a", 1,0,0,32'h0, 0, 0,32'h0, 0, 0,1,32'h0, 32'h0));
        apply_vec(mk("rst_b", 1,0,0,32'h0, 0, 0,32'h0, 0, 0,1,32'h0, 32'h0));

        // ready every 2nd cycle: addrs 0,4,8 -> PC 4,8,12
        run_stream(3, 2, 32'h0);
        // latency 3: two fetch_stall cycles per request, addrs 12,16
        run_stream(2, 3, 32'hC);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i]);
        end

        @(negedge clk);
        check_q();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
